lfsr_prng: RTL

Parametrised, stream-output pseudo-random generator: the next generation of the team's 32-bit Fibonacci LFSR. It generalises width, tap polynomial and bits-advanced-per-word, and adds a ready/valid output, run-time reseeding, a warm-up discard phase and an accepted-word counter. It feeds DES test-vector and masking-randomness consumers that apply backpressure.

---
 rtl/lfsr_pkg.sv | 48 ++++
 rtl/lfsr_advance.sv | 34 +++
 rtl/lfsr_prng.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the stream LFSR generator (lfsr_prng).
//   - lfsr_state_e   : sequencing states (warm-up discard / streaming)
//   - LFSR_TAP_*     : named Fibonacci tap masks, bit p-1 set => tap at position p
//   - lfsr_shift1()  : one Fibonacci shift of a right-aligned state vector
// -----------------------------------------------------------------------------
package lfsr_pkg;

    // Widest LFSR the shift helper handles; states are right-aligned in it.
    localparam int LFSR_MAX_W = 64;

    typedef enum logic [0:0] {
        LFSR_WARM = 1'b0,
        LFSR_RUN  = 1'b1
    } lfsr_state_e;

    // Taps 32,22,2,1: the legacy DES test-vector polynomial.
    localparam logic [31:0] LFSR_TAP_DES32 = 32'h8020_0003;
    // Taps 8,6,5,4.
    localparam logic [7:0]  LFSR_TAP_8     = 8'hB8;
    // Taps 16,14,13,11.
    localparam logic [15:0] LFSR_TAP_16    = 16'hB400;
    // Taps 64,63,61,60.
    localparam logic [63:0] LFSR_TAP_64    = 64'hD800_0000_0000_0000;

    // Position p (1..w) of the state lives in vector bit w-p, so position 1
    // is the MSB. The feedback bit enters at position 1 and everything else
    // moves one position towards w. Bits at or above w must be zero.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_shift1(
        input logic [LFSR_MAX_W-1:0] q,
        input logic [LFSR_MAX_W-1:0] mask,
        input int                    w
    );
        logic                  fb;
        logic [LFSR_MAX_W-1:0] nxt;
        fb = 1'b0;
        for (int p = 1; p <= LFSR_MAX_W; p++) begin
            if ((p <= w) && mask[p-1]) begin
                fb = fb ^ q[w-p];
            end
        end
        nxt      = q >> 1;
        nxt[w-1] = fb;
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_advance.sv
// -----------------------------------------------------------------------------
// lfsr_advance
// Purely combinational: applies STEPS chained Fibonacci shifts to a state.
// Parameters: WIDTH (state length), TAP_MASK (bit p-1 => tap at position p),
//             STEPS (shifts per advance, 1..WIDTH).
// Ports:
//   i_q  in  WIDTH  current state
//   o_q  out WIDTH  state after STEPS shifts
// -----------------------------------------------------------------------------
module lfsr_advance
    import lfsr_pkg::*;
#(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  TAP_MASK = WIDTH'(LFSR_TAP_DES32),
    parameter int                STEPS    = 1
) (
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_q
);

    localparam logic [LFSR_MAX_W-1:0] MASK_EXT = LFSR_MAX_W'(TAP_MASK);

    logic [LFSR_MAX_W-1:0] w_acc;

    always_comb begin
        w_acc = '0;
        w_acc[WIDTH-1:0] = i_q;
        for (int s = 0; s < STEPS; s++) begin
            w_acc = lfsr_shift1(w_acc, MASK_EXT, WIDTH);
        end
        o_q = w_acc[WIDTH-1:0];
    end

endmodule

// File: rtl/lfsr_prng.sv
// -----------------------------------------------------------------------------
// lfsr_prng
// Stream-output Fibonacci LFSR generator with ready/valid handshake,
// run-time reseeding, warm-up discard and an accepted-word counter.
//
// Optional feature macro: LFSR_LOCKUP_FIX_EN
//   defined   - a zero seed loads 1 instead and sets the sticky lockup flag
//   undefined - zero seeds load as-is, lockup tied low
//
// Parameters: WIDTH, TAP_MASK, STEPS, WARMUP (0..255), CNT_W
// Ports:
//   clk        in   1      clock, posedge
//   rst        in   1      synchronous active-low reset (acts as a load)
//   seed       in   WIDTH  seed sampled on reset and on seed_load
//   seed_load  in   1      reseed request
//   out_ready  in   1      consumer ready
//   out_valid  out  1      out_data holds a fresh word
//   out_data   out  WIDTH  current LFSR state
//   word_cnt   out  CNT_W  accepted words since last load (wraps)
//   lockup     out  1      sticky: a zero seed was replaced
// -----------------------------------------------------------------------------
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  TAP_MASK = WIDTH'(LFSR_TAP_DES32),
    parameter int                STEPS    = 1,
    parameter int                WARMUP   = 0,
    parameter int                CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] word_cnt,
    output logic             lockup
);

    // state | meaning
    // WARM  | discarding WARMUP advances after a load, out_valid low
    // RUN   | streaming, one advance per accepted word
    localparam logic [0:0] ST_WARM = LFSR_WARM;
    localparam logic [0:0] ST_RUN  = LFSR_RUN;

    localparam logic [7:0] WARM_INIT = 8'(WARMUP);
    localparam logic [0:0] ST_LOAD   = (WARMUP > 0) ? ST_WARM : ST_RUN;

    logic [WIDTH-1:0] r_q;
    logic [0:0]       r_state;
    logic [7:0]       r_warm;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_adv;
    logic [WIDTH-1:0] w_load_val;
    logic             w_load;
    logic             w_accept;

    lfsr_advance #(
        .WIDTH    (WIDTH),
        .TAP_MASK (TAP_MASK),
        .STEPS    (STEPS)
    ) u_advance (
        .i_q (r_q),
        .o_q (w_adv)
    );

    // Reset is just a load that also clears the sticky flag.
    assign w_load   = !rst || seed_load;
    assign w_accept = (r_state == ST_RUN) && out_ready;

`ifdef LFSR_LOCKUP_FIX_EN
    logic w_seed_zero;
    logic r_lockup;

    assign w_seed_zero = (seed == '0);
    // An all-zero Fibonacci state never leaves zero; substitute q[WIDTH]=1.
    assign w_load_val  = w_seed_zero ? WIDTH'(1) : seed;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lockup <= w_seed_zero;
        end else if (seed_load && w_seed_zero) begin
            r_lockup <= 1'b1;
        end
    end

    assign lockup = r_lockup;
`else
    assign w_load_val = seed;
    assign lockup     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_load) begin
            // A same-cycle accept has already been seen by the consumer;
            // the load simply wins for the internal state.
            r_q     <= w_load_val;
            r_cnt   <= '0;
            r_warm  <= WARM_INIT;
            r_state <= ST_LOAD;
        end else begin
            case (r_state)
                ST_WARM: begin
                    r_q    <= w_adv;
                    r_warm <= r_warm - 8'd1;
                    if (r_warm == 8'd1) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_q   <= w_adv;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign out_valid = (r_state == ST_RUN);
    assign out_data  = r_q;
    assign word_cnt  = r_cnt;

endmodule
